// File: rtl/led_matrix_scan_controller.sv
// Register-mapped LED matrix scanner: framebuffer plus CTRL/STATUS registers, one-row-at-a-time
// multiplexing with a blanking phase and an 8-bit PWM brightness phase per row slot.
module led_matrix_scan_controller #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int PRESCALE    = 4,
  parameter int BLANK_TICKS = 2
) (
  input  logic            clk_i,
  input  logic            rst,
  input  logic [31:0]     led_addr_i,
  input  logic [31:0]     led_wdata_i,
  input  logic            led_we_i,
  output logic [31:0]     led_rdata_o,
  output logic [ROWS-1:0] row_o,
  output logic [COLS-1:0] col_o,
  output logic            frame_tick_o
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  logic [5:0]           word_sel, row_off;
  logic                 row_hit, ctrl_we, row_we, clear_hit;
  logic                 enable_reg;
  logic [7:0]           bright_reg, bright_next;
  logic [ROWS*COLS-1:0] fb_flat;
  logic [1:0]           state_reg, state_next;
  logic [RW-1:0]        row_reg, row_next;
  logic [PW-1:0]        presc_reg, presc_next;
  logic [BW-1:0]        blank_reg, blank_next;
  logic [7:0]           pwm_reg, pwm_next;
  logic [7:0]           frame_cnt_reg;
  logic                 tick, enter_blank, frame_wrap;
  logic [ROWS-1:0]      row_onehot;
  logic                 unused_bits;

  assign unused_bits = ^{led_addr_i[31:8], led_addr_i[1:0], led_wdata_i};

  assign word_sel  = led_addr_i[7:2];
  assign row_off   = word_sel - 6'd16;
  assign row_hit   = (word_sel >= 6'd16) && ({1'b0, row_off} < 7'(ROWS));
  assign ctrl_we   = led_we_i && (word_sel == 6'd0);
  assign row_we    = led_we_i && row_hit;
  assign clear_hit = ctrl_we && led_wdata_i[1];

  // Clear takes priority over a row write landing on the same edge.
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      logic [COLS-1:0] bits_reg;
      always_ff @(posedge clk_i) begin
        if (rst || clear_hit) begin
          bits_reg <= '0;
        end else if (row_we && row_off == 6'(gi)) begin
          bits_reg <= led_wdata_i[COLS-1:0];
        end
      end
      assign fb_flat[gi*COLS +: COLS] = bits_reg;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst) begin
      enable_reg <= 1'b0;
      bright_reg <= 8'h80;
    end else if (ctrl_we) begin
      enable_reg <= led_wdata_i[0];
      bright_reg <= led_wdata_i[15:8];
    end
  end

  assign bright_next = ctrl_we ? led_wdata_i[15:8] : bright_reg;

  always_comb begin
    led_rdata_o = '0;
    if (word_sel == 6'd0) begin
      led_rdata_o = {16'h0, bright_reg, 7'h0, enable_reg};
    end else if (word_sel == 6'd1) begin
      led_rdata_o[31:24] = frame_cnt_reg;
      led_rdata_o[16]    = (state_reg != S_IDLE);
      led_rdata_o[RW-1:0] = row_reg;
    end else if (row_hit) begin
      led_rdata_o[COLS-1:0] = fb_flat[int'(row_off)*COLS +: COLS];
    end
  end

  assign tick = (state_reg != S_IDLE) && (presc_reg == PW'(PRESCALE - 1));

  always_comb begin
    state_next  = state_reg;
    row_next    = row_reg;
    presc_next  = presc_reg;
    blank_next  = blank_reg;
    pwm_next    = pwm_reg;
    enter_blank = 1'b0;
    frame_wrap  = 1'b0;
    if (state_reg != S_IDLE) begin
      presc_next = tick ? '0 : presc_reg + 1'b1;
    end
    case (state_reg)
      S_IDLE: begin
        if (enable_reg) begin
          state_next  = S_BLANK;
          row_next    = '0;
          blank_next  = '0;
          enter_blank = 1'b1;
        end
      end
      S_BLANK: begin
        if (tick) begin
          if (blank_reg == BW'(BLANK_TICKS - 1)) begin
            state_next = S_DRIVE;
            pwm_next   = '0;
          end else begin
            blank_next = blank_reg + 1'b1;
          end
        end
      end
      S_DRIVE: begin
        if (tick) begin
          if (pwm_reg == 8'hFF) begin
            state_next  = S_BLANK;
            blank_next  = '0;
            enter_blank = 1'b1;
            if (row_reg == RW'(ROWS - 1)) begin
              row_next   = '0;
              frame_wrap = 1'b1;
            end else begin
              row_next = row_reg + 1'b1;
            end
          end else begin
            pwm_next = pwm_reg + 8'd1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
    // Disabling overrides any progress and parks everything at the start of a frame.
    if (!enable_reg) begin
      state_next  = S_IDLE;
      row_next    = '0;
      presc_next  = '0;
      blank_next  = '0;
      pwm_next    = '0;
      enter_blank = 1'b0;
      frame_wrap  = 1'b0;
    end
  end

  always_comb begin
    row_onehot           = '0;
    row_onehot[row_next] = 1'b1;
  end

  // Outputs are derived from the next state so they line up with the state they describe.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      row_reg       <= '0;
      presc_reg     <= '0;
      blank_reg     <= '0;
      pwm_reg       <= '0;
      frame_cnt_reg <= '0;
      row_o         <= '0;
      col_o         <= '0;
      frame_tick_o  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      row_reg      <= row_next;
      presc_reg    <= presc_next;
      blank_reg    <= blank_next;
      pwm_reg      <= pwm_next;
      frame_tick_o <= frame_wrap;
      if (frame_wrap) begin
        frame_cnt_reg <= frame_cnt_reg + 8'd1;
      end
      if (state_next == S_IDLE) begin
        col_o <= '0;
      end else if (enter_blank) begin
        col_o <= fb_flat[int'(row_next)*COLS +: COLS];
      end
      row_o <= (state_next == S_DRIVE && pwm_next < bright_next) ? row_onehot : '0;
    end
  end
endmodule

// File: tb/tb_led_matrix_scan_controller.sv
// Bench for led_matrix_scan_controller: a time-since-scan-start model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_led_matrix_scan_controller;
  localparam int ROWS        = 8;
  localparam int COLS        = 8;
  localparam int PRESCALE    = 4;
  localparam int BLANK_TICKS = 2;
  localparam int RW          = $clog2(ROWS);
  localparam int BP          = BLANK_TICKS * PRESCALE;
  localparam int SLOT        = (BLANK_TICKS + 256) * PRESCALE;
  localparam int FRAME       = SLOT * ROWS;

  logic            clk   = 1'b0;
  logic            rst   = 1'b1;
  logic [31:0]     addr  = '0;
  logic [31:0]     wdata = '0;
  logic            we    = 1'b0;
  logic [31:0]     rdata;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] col;
  logic            ftick;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_matrix_scan_controller #(
    .ROWS(ROWS), .COLS(COLS), .PRESCALE(PRESCALE), .BLANK_TICKS(BLANK_TICKS)
  ) dut (
    .clk_i(clk), .rst(rst), .led_addr_i(addr), .led_wdata_i(wdata), .led_we_i(we),
    .led_rdata_o(rdata), .row_o(row), .col_o(col), .frame_tick_o(ftick)
  );

  // Model state: register contents plus the number of clocks since scanning began.
  logic            m_en;
  logic [7:0]      m_bright;
  logic [COLS-1:0] m_fb [ROWS];
  logic [7:0]      m_fcnt;
  bit              m_scan;
  int              m_t;
  logic [COLS-1:0] m_col;
  logic [ROWS-1:0] m_row;
  bit              m_tick;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int w;
    logic [31:0] r;
    w = int'(a[7:2]);
    r = '0;
    if (w == 0) begin
      r = {16'h0, m_bright, 7'h0, m_en};
    end else if (w == 1) begin
      r[31:24] = m_fcnt;
      r[16]    = m_scan;
      if (m_scan) r[RW-1:0] = RW'((m_t / SLOT) % ROWS);
    end else if (w >= 16 && w - 16 < ROWS) begin
      r[COLS-1:0] = m_fb[w-16];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin : model
    logic [COLS-1:0] fb_old [ROWS];
    bit en_old;
    int w, o, slot;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_en = 1'b0; m_bright = 8'h80; m_fcnt = '0;
        for (int r = 0; r < ROWS; r++) m_fb[r] = '0;
        m_scan = 0; m_t = 0; m_col = '0; m_row = '0; m_tick = 0;
      end else begin
        fb_old = m_fb;
        en_old = m_en;
        w = int'(addr[7:2]);
        if (we && w == 0) begin
          m_en = wdata[0];
          m_bright = wdata[15:8];
          if (wdata[1]) for (int r = 0; r < ROWS; r++) m_fb[r] = '0;
        end else if (we && w >= 16 && w - 16 < ROWS) begin
          m_fb[w-16] = wdata[COLS-1:0];
        end
        m_tick = 0;
        if (!en_old) begin
          m_scan = 0; m_t = 0;
        end else if (!m_scan) begin
          m_scan = 1; m_t = 0;
        end else begin
          m_t++;
        end
        if (m_scan) begin
          o = m_t % SLOT;
          slot = m_t / SLOT;
          if (o == 0) m_col = fb_old[slot % ROWS];
          if (m_t > 0 && m_t % FRAME == 0) begin
            m_tick = 1;
            m_fcnt = m_fcnt + 8'd1;
          end
          m_row = (o >= BP && (o - BP) / PRESCALE < int'(m_bright)) ? ROWS'(1 << (slot % ROWS)) : '0;
        end else begin
          m_row = '0;
          m_col = '0;
        end
      end
    end
  end

  initial begin : compare
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("row_o", 32'(row), 32'(m_row));
      check("col_o", 32'(col), 32'(m_col));
      check("frame_tick_o", 32'(ftick), 32'(m_tick));
      check("rdata", rdata, model_read(addr));
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input int hold);
    @(posedge clk); #1;
    addr = a; wdata = d; we = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    we = 1'b0; wdata = '0; addr = 32'h4;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    @(posedge clk); #1;
    addr = a; #1;
    check(name, rdata, exp);
  endtask

  task automatic wait_row(input string name, input logic [ROWS-1:0] v, input bit any,
                          input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((any && row != '0) || (!any && row === v)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL %s: row_o did not reach 0x%0h within %0d cycles", name, v, budget);
    end
  endtask

  task automatic wait_tick(input string name, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ftick === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL %s: frame_tick_o absent for %0d cycles", name, budget);
    end
  endtask

  task automatic wait_col_change(input string name, input int budget);
    logic [COLS-1:0] p;
    bit seen;
    p = col;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (col !== p) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: col_o unchanged for %0d cycles", name, budget);
    end
  endtask

  initial begin : stim
    int t0, t1, t2, lit, chg;
    logic [COLS-1:0] prev;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; addr = 32'h0; #1;
    check("reset_ctrl", rdata, 32'h8000);
    check("reset_row_o", 32'(row), 32'h0);

    // Register read/write, address masking and a write held for several cycles.
    wr(32'h40, 32'hA5, 1);
    wr(32'h5C, 32'h1FF, 1);
    wr(32'hFFFF_0048, 32'h3C, 3);
    rd("row0", 32'h40, 32'hA5);
    rd("row7_masked", 32'h5C, 32'hFF);
    rd("row8_absent", 32'h60, 32'h0);
    rd("unmapped_08", 32'h08, 32'h0);
    rd("row2_held_write", 32'h48, 32'h3C);
    rd("status_idle", 32'h04, 32'h0);

    // Scan order and frame timing.
    for (int r = 0; r < ROWS; r++) wr(32'h40 + 32'(4 * r), 32'(r + 1), 1);
    wr(32'h0, 32'hFF01, 1);
    t0 = cyc;
    wait_row("first_row", 8'h01, 0, 50, t1);
    check("first_lit_latency", 32'(t1 - t0), 32'd9);
    check("first_col", 32'(col), 32'h1);
    wait_row("second_row", 8'h02, 0, 2000, t2);
    check("slot_spacing", 32'(t2 - t1), 32'd1032);
    check("second_col", 32'(col), 32'h2);
    wait_row("last_row", 8'h80, 0, 8000, t2);
    check("last_col", 32'(col), 32'h8);
    wait_tick("frame1", 9000, t1);
    check("frame1_time", 32'(t1 - t0), 32'd8257);
    check("frame1_cnt", 32'(rdata[31:24]), 32'd1);
    wait_tick("frame2", 9000, t2);
    check("frame_spacing", 32'(t2 - t1), 32'd8256);
    check("frame2_cnt", 32'(rdata[31:24]), 32'd2);

    // PWM: brightness 0x40 lights 256 clocks per slot; brightness 0 never lights.
    wr(32'h0, 32'h4001, 1);
    wait_col_change("pwm64_slot_start", 1100);
    lit = 0;
    for (int i = 0; i < SLOT; i++) begin
      @(negedge clk);
      if (row != '0) lit++;
    end
    check("pwm64_lit_clocks", 32'(lit), 32'd256);
    wr(32'h0, 32'h0001, 1);
    wait_col_change("pwm0_slot_start", 1100);
    lit = 0; chg = 0; prev = col;
    for (int i = 0; i < SLOT; i++) begin
      @(negedge clk);
      if (row != '0) lit++;
      if (col !== prev) chg++;
      prev = col;
    end
    check("pwm0_lit_clocks", 32'(lit), 32'd0);
    check("pwm0_col_updates", 32'(chg), 32'd1);

    // A row rewritten during its own drive keeps the latched value until its next blank.
    wr(32'h0, 32'hFF01, 1);
    wait_row("row2_drive", 8'h04, 0, 9000, t1);
    wr(32'h48, 32'h0, 1);
    check("no_tear_col", 32'(col), 32'h3);
    rd("row2_rewritten", 32'h48, 32'h0);
    wait_row("row3_drive", 8'h08, 0, 2000, t1);
    check("row3_col", 32'(col), 32'h4);
    wait_row("row2_again", 8'h04, 0, 9000, t1);
    check("row2_new_col", 32'(col), 32'h0);

    // Clear, then disable mid-drive.
    wr(32'h0, 32'h8003, 1);
    for (int r = 0; r < ROWS; r++) rd("cleared_row", 32'h40 + 32'(4 * r), 32'h0);
    rd("ctrl_after_clear", 32'h0, 32'h8001);
    wait_row("drive_before_disable", '0, 1, 2000, t1);
    wr(32'h0, 32'h0, 1);
    @(posedge clk); #1;
    addr = 32'h4; #1;
    check("disabled_row_o", 32'(row), 32'h0);
    check("disabled_col_o", 32'(col), 32'h0);
    check("disabled_scanning", 32'(rdata[16]), 32'h0);
    check("disabled_status_row", 32'(rdata[RW-1:0]), 32'h0);

    // Reset in the middle of row 5's drive.
    wr(32'h54, 32'h5A, 1);
    wr(32'h0, 32'hFF01, 1);
    wait_row("row5_drive", 8'h20, 0, 8000, t1);
    check("row5_col", 32'(col), 32'h5A);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_row_o", 32'(row), 32'h0);
    check("rst_col_o", 32'(col), 32'h0);
    check("rst_frame_tick", 32'(ftick), 32'h0);
    addr = 32'h0; #1;
    check("rst_ctrl", rdata, 32'h8000);
    addr = 32'h4; #1;
    check("rst_frame_cnt", 32'(rdata[31:24]), 32'h0);
    rst = 1'b0;
    repeat (20) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
